cic_comb_mc: RTL and testbench
==============================

# cic_comb_mc

Parametrised, pipelined, multi-channel comb (differentiator) section for the Mul_CIC decimator. It sits after the integrator chain and the decimating sampler. It accepts one decimated sample per qualifying `nd` cycle, tagged with a channel index. It applies STAGES cascaded differentiators with differential delay DIFF_DELAY per channel, then narrows the result to OUT_WIDTH bits with a registered output and valid strobe.

## Interface
- WIDTH, 44: internal and input word width (two's complement); sized for integrator growth.
- STAGES, 6: number of comb stages, 1..8.
- DIFF_DELAY, 1: differential delay M per stage, 1 or 2.
- CHANNELS, 1: number of time-multiplexed channels, 1..16.
- OUT_WIDTH, 24: output width, 1..WIDTH; the top OUT_WIDTH bits of the comb result are kept.
- CH_W, derived: max(1, clog2(CHANNELS)).
- clk  in  1  system clock (512 kHz in current build).
- rst  in  1  asynchronous, active-low reset; asserted while 0.
- nd  in  1  new-data strobe; `xin` and `xin_ch` are sampled when 1.
- xin  in  WIDTH  signed input sample.
- xin_ch  in  CH_W  channel of `xin`.
- yout  out  OUT_WIDTH  signed filtered output.
- yout_ch  out  CH_W  channel of `yout`.
- yout_valid  out  1  one-cycle strobe marking `yout`/`yout_ch` valid.
- ch_err  out  1  one-cycle strobe: `nd` seen with `xin_ch` >= CHANNELS.

## Operation
- Per stage k and channel c, a delay line of DIFF_DELAY words holds past stage inputs.
- Stage k computes y = x − x[n−M] for the sample's channel, then shifts the delay line (newest in).
- Delay lines for channel c advance only on samples of channel c. Other channels are untouched.
- Arithmetic is modular at WIDTH bits. Wrap-around is intended and must not be saturated, because it is cancelled by integrator wrap.
- Output narrowing discards the low WIDTH−OUT_WIDTH bits (see Configuration).
- If `nd`=1 and `xin_ch` >= CHANNELS:
  - the sample is dropped and no state changes;
  - `ch_err` pulses one cycle later;
  - no `yout_valid` results.
- There is no backpressure. `nd` may be high on every cycle, with any channel order, including back-to-back samples of the same channel.
- Reset (rst=0) at any time, including mid-pipeline:
  - all delay lines, pipeline registers, `yout`, `yout_ch`, `yout_valid` and `ch_err` are cleared to 0 immediately;
  - in-flight samples are discarded.

## Timing
- One pipeline register per stage plus one output register.
- `nd` at cycle t gives `yout_valid`=1 at cycle t+STAGES+1.
- Throughput is one sample per cycle.
- Samples leave in arrival order. A sample of channel c reads stage-k delay state only after every earlier channel-c sample has written it, which holds by pipeline ordering and needs no forwarding.
- `yout` and `yout_ch` hold their last value when `yout_valid`=0.
- First qualifying edge after rst deasserts is the first sample.

## Configuration
- COMB_ROUND_EN:
  - Defined: round-half-up on narrowing. Add 2^(WIDTH−OUT_WIDTH−1) before discarding bits. If that addition overflows positive, saturate `yout` to +(2^(OUT_WIDTH−1)−1).
  - Undefined: plain truncation (floor), with no saturation logic.
  - With OUT_WIDTH = WIDTH, both builds are identical.

## Structure
- Package `cic_pkg`:
  - clog2 function;
  - default WIDTH/STAGES/OUT_WIDTH constants;
  - a `cic_sample_t`-style bundle (valid, ch, data) shared with the integrator side.
- Sub-module `cic_comb_stage`: one registered differentiator with its per-channel DIFF_DELAY delay line. It is generated STAGES times. The top level handles channel check, narrowing and output register.

## Test plan
- Impulse, CHANNELS=1, STAGES=6, M=1, OUT_WIDTH=WIDTH: xin=1 then 0s → yout 1,−6,15,−20,15,−6,1, then 0. First valid is 7 cycles after `nd`.
- Step: xin=5 constant, same config → 5,−25,50,−50,25,−5, then 0 thereafter.
- Interleave, CHANNELS=2, `nd` every cycle alternating ch0/ch1:
  - ch0 impulse with ch1 all zero → ch0 binomial sequence, ch1 all 0;
  - `yout_ch` alternates matching input.
- Wrap, WIDTH=8, STAGES=1, OUT_WIDTH=8: xin 127 then −128 → second yout = 1. Invalid ch=3 with CHANNELS=2 → `ch_err` pulse and no `yout_valid`.
- Narrowing, WIDTH=44, OUT_WIDTH=24, STAGES=1: comb output 0x80000.
  - With COMB_ROUND_EN: yout=1.
  - Without: yout=0.
  - Comb output 0x7FFFFFFFFFF with COMB_ROUND_EN → 0x7FFFFF.
- Reset mid-stream: rst=0 while 3 samples are in flight → outputs 0 immediately and no `yout_valid` from those samples. After release, an impulse gives the clean binomial response.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and helpers for the Mul_CIC decimator datapath.
// Provides clog2, default sizes and the sample bundle used on both sides.
package cic_pkg;

  localparam int CIC_WIDTH     = 44;
  localparam int CIC_STAGES    = 6;
  localparam int CIC_OUT_WIDTH = 24;
  localparam int CIC_CH_W      = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [CIC_CH_W-1:0] ch;
    logic [CIC_WIDTH-1:0] data;
  } cic_sample_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb (y = x - x[n-M]) with a per-channel delay line.
// Ports: clk, rst (async low), in_v/ch/d_i sample in, out_v/ch/d_o sample out.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WIDTH    = CIC_WIDTH,
  parameter int M        = 1,
  parameter int CHANNELS = 1,
  parameter int CH_W     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_v_i,
  input  logic [CH_W-1:0]  in_ch_i,
  input  logic [WIDTH-1:0] in_d_i,
  output logic             out_v_o,
  output logic [CH_W-1:0]  out_ch_o,
  output logic [WIDTH-1:0] out_d_o
);

  logic [WIDTH-1:0] dl_q [CHANNELS][M];
  logic             v_q;
  logic [CH_W-1:0]  ch_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] old_w;

  // Oldest word of the sample's own channel.
  always_comb begin
    old_w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_ch_i == CH_W'(c)) old_w = dl_q[c][M-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q  <= 1'b0;
      ch_q <= '0;
      d_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int j = 0; j < M; j++) begin
          dl_q[c][j] <= '0;
        end
      end
    end else begin
      v_q <= in_v_i;
      if (in_v_i) begin
        ch_q <= in_ch_i;
        d_q  <= in_d_i - old_w;
        for (int c = 0; c < CHANNELS; c++) begin
          if (in_ch_i == CH_W'(c)) begin
            dl_q[c][0] <= in_d_i;
            for (int j = 1; j < M; j++) begin
              dl_q[c][j] <= dl_q[c][j-1];
            end
          end
        end
      end
    end
  end

  assign out_v_o  = v_q;
  assign out_ch_o = ch_q;
  assign out_d_o  = d_q;

endmodule

// File: rtl/cic_comb_mc.sv
// Multi-channel pipelined CIC comb section with narrowed registered output.
// Ports: clk, rst (async low), nd/xin/xin_ch in; yout/yout_ch/yout_valid, ch_err out.
// Build option: COMB_ROUND_EN selects round-half-up with positive saturation.
module cic_comb_mc
  import cic_pkg::*;
#(
  parameter int WIDTH      = CIC_WIDTH,
  parameter int STAGES     = CIC_STAGES,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 1,
  parameter int OUT_WIDTH  = CIC_OUT_WIDTH,
  localparam int CH_W      = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        nd,
  input  logic        [WIDTH-1:0]     xin,
  input  logic        [CH_W-1:0]      xin_ch,
  output logic signed [OUT_WIDTH-1:0] yout,
  output logic        [CH_W-1:0]      yout_ch,
  output logic                        yout_valid,
  output logic                        ch_err
);

  localparam int SH = WIDTH - OUT_WIDTH;

  logic             ch_ok;
  logic             v_w  [STAGES+1];
  logic [CH_W-1:0]  c_w  [STAGES+1];
  logic [WIDTH-1:0] d_w  [STAGES+1];
  logic [OUT_WIDTH-1:0] y_n;

  logic                 yv_q;
  logic [OUT_WIDTH-1:0] y_q;
  logic [CH_W-1:0]      ych_q;
  logic                 err_q;

  assign ch_ok  = ({1'b0, xin_ch} < (CH_W+1)'(CHANNELS));
  assign v_w[0] = nd & ch_ok;
  assign c_w[0] = xin_ch;
  assign d_w[0] = xin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cic_comb_stage #(
      .WIDTH    (WIDTH),
      .M        (DIFF_DELAY),
      .CHANNELS (CHANNELS),
      .CH_W     (CH_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_v_i   (v_w[k]),
      .in_ch_i  (c_w[k]),
      .in_d_i   (d_w[k]),
      .out_v_o  (v_w[k+1]),
      .out_ch_o (c_w[k+1]),
      .out_d_o  (d_w[k+1])
    );
  end

  if (SH == 0) begin : g_full
    assign y_n = d_w[STAGES];
  end else begin : g_narrow
`ifdef COMB_ROUND_EN
    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (SH - 1);
    localparam logic [OUT_WIDTH-1:0] MAXP =
      ~(OUT_WIDTH'(1) << (OUT_WIDTH - 1));
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic             unused_lo;
    assign sum       = d_w[STAGES] + HALF;
    // Only a non-negative value can carry into the sign bit.
    assign ovf       = ~d_w[STAGES][WIDTH-1] & sum[WIDTH-1];
    assign y_n       = ovf ? MAXP : sum[WIDTH-1:SH];
    assign unused_lo = ^sum[SH-1:0];
`else
    logic unused_lo;
    assign y_n       = d_w[STAGES][WIDTH-1:SH];
    assign unused_lo = ^d_w[STAGES][SH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yv_q  <= 1'b0;
      y_q   <= '0;
      ych_q <= '0;
      err_q <= 1'b0;
    end else begin
      yv_q  <= v_w[STAGES];
      err_q <= nd & ~ch_ok;
      if (v_w[STAGES]) begin
        y_q   <= y_n;
        ych_q <= c_w[STAGES];
      end
    end
  end

  assign yout       = y_q;
  assign yout_ch    = ych_q;
  assign yout_valid = yv_q;
  assign ch_err     = err_q;

endmodule

// File: tb/tb_cic_comb_mc.sv
// Scoreboard bench for cic_comb_mc: three configurations driven in turn.
// A: 44b/6 stages/3 ch, B: 8b wrap, C: 44->24 narrowing with M=2.
module tb_cic_comb_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        nd_a;
  logic [43:0] xin_a, y_a;
  logic [1:0]  xch_a, ych_a;
  logic        yv_a, err_a;

  logic        nd_b;
  logic [7:0]  xin_b, y_b;
  logic        xch_b, ych_b;
  logic        yv_b, err_b;

  logic        nd_c;
  logic [43:0] xin_c;
  logic [23:0] y_c;
  logic        xch_c, ych_c;
  logic        yv_c, err_c;

  cic_comb_mc #(.WIDTH(44), .STAGES(6), .DIFF_DELAY(1),
                .CHANNELS(3), .OUT_WIDTH(44)) dut_a (
    .clk(clk), .rst(rst), .nd(nd_a), .xin(xin_a), .xin_ch(xch_a),
    .yout(y_a), .yout_ch(ych_a), .yout_valid(yv_a), .ch_err(err_a));

  cic_comb_mc #(.WIDTH(8), .STAGES(1), .DIFF_DELAY(1),
                .CHANNELS(2), .OUT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .nd(nd_b), .xin(xin_b), .xin_ch(xch_b),
    .yout(y_b), .yout_ch(ych_b), .yout_valid(yv_b), .ch_err(err_b));

  cic_comb_mc #(.WIDTH(44), .STAGES(1), .DIFF_DELAY(2),
                .CHANNELS(1), .OUT_WIDTH(24)) dut_c (
    .clk(clk), .rst(rst), .nd(nd_c), .xin(xin_c), .xin_ch(xch_c),
    .yout(y_c), .yout_ch(ych_c), .yout_valid(yv_c), .ch_err(err_c));

  typedef struct {
    longint d;
    int     ch;
    int     cyc;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int   err_cyc_a[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   nerr_a = 0;
  longint last_a = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_unexp(input string nm);
    nvec++;
    nfail++;
    $display("FAIL %s: output strobe with nothing expected (cycle %0d)",
             nm, cyc);
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_a = 0;
    end else begin
      if (yv_a) begin
        if (qa.size() == 0) fail_unexp("a_valid");
        else begin
          e = qa.pop_front();
          chk("a_data", $signed(y_a), e.d);
          chk("a_ch", ych_a, e.ch);
          chk("a_latency", cyc, e.cyc);
        end
        last_a = $signed(y_a);
      end else begin
        chk("a_hold", $signed(y_a), last_a);
      end
      if (err_a) begin
        nerr_a++;
        if (err_cyc_a.size() == 0) fail_unexp("a_ch_err");
        else chk("a_ch_err_cycle", cyc, err_cyc_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && yv_b) begin
      if (qb.size() == 0) fail_unexp("b_valid");
      else begin
        e = qb.pop_front();
        chk("b_data", $signed(y_b), e.d);
        chk("b_ch", ych_b, e.ch);
        chk("b_latency", cyc, e.cyc);
      end
    end
    if (rst && err_b) fail_unexp("b_ch_err");
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && yv_c) begin
      if (qc.size() == 0) fail_unexp("c_valid");
      else begin
        e = qc.pop_front();
        chk("c_data", $signed(y_c), e.d);
        chk("c_latency", cyc, e.cyc);
      end
    end
    if (rst && err_c) fail_unexp("c_ch_err");
  end

  // Drivers
  task automatic send_a(input int ch, input longint x,
                        input bit ok, input longint e);
    @(negedge clk);
    nd_a  = 1'b1;
    xin_a = x[43:0];
    xch_a = ch[1:0];
    if (ok) qa.push_back('{d: e, ch: ch, cyc: cyc + 7});
    else    err_cyc_a.push_back(cyc + 1);
  endtask

  task automatic send_b(input int ch, input longint x, input longint e);
    @(negedge clk);
    nd_b  = 1'b1;
    xin_b = x[7:0];
    xch_b = ch[0];
    qb.push_back('{d: e, ch: ch, cyc: cyc + 2});
  endtask

  task automatic send_c(input longint x, input longint e);
    @(negedge clk);
    nd_c  = 1'b1;
    xin_c = x[43:0];
    qc.push_back('{d: e, ch: 0, cyc: cyc + 2});
  endtask

  task automatic idle();
    @(negedge clk);
    nd_a = 1'b0;
    nd_b = 1'b0;
    nd_c = 1'b0;
  endtask

  longint imp  [10] = '{1, -6, 15, -20, 15, -6, 1, 0, 0, 0};
  longint step [10] = '{5, -25, 50, -50, 25, -5, 0, 0, 0, 0};
  longint c_x  [5];
  longint c_e  [5];

  initial begin
    rst = 1'b0;
    nd_a = 1'b0; xin_a = '0; xch_a = '0;
    nd_b = 1'b0; xin_b = '0; xch_b = '0;
    nd_c = 1'b0; xin_c = '0; xch_c = '0;

    repeat (3) @(negedge clk);
    chk("rst_a_yout", y_a, 0);
    chk("rst_a_valid", yv_a, 0);
    chk("rst_a_ch", ych_a, 0);
    chk("rst_a_ch_err", err_a, 0);
    chk("rst_b_yout", y_b, 0);
    chk("rst_c_yout", y_c, 0);
    #2 rst = 1'b1;

    // Impulse on ch0
    for (int i = 0; i < 10; i++) send_a(0, (i == 0) ? 1 : 0, 1, imp[i]);
    // Step on ch1, back to back
    for (int i = 0; i < 10; i++) send_a(1, 5, 1, step[i]);
    // Interleave ch0 impulse with ch2 zeros, one bad channel inside
    for (int i = 0; i < 8; i++) begin
      send_a(0, (i == 0) ? 1 : 0, 1, imp[i]);
      send_a(2, 0, 1, 0);
      if (i == 2) send_a(3, 99, 0, 0);
    end
    idle();
    repeat (10) @(negedge clk);

    // Reset while the ch2 impulse is in flight
    for (int i = 0; i < 10; i++) send_a(2, (i == 0) ? 1 : 0, 1, imp[i]);
    idle();
    #2 rst = 1'b0;
    qa.delete();
    #1;
    chk("midrst_yout", y_a, 0);
    chk("midrst_valid", yv_a, 0);
    chk("midrst_ch", ych_a, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    // ch1 held step state before reset; it must start clean
    for (int i = 0; i < 10; i++) send_a(1, (i == 0) ? 1 : 0, 1, imp[i]);
    idle();
    repeat (10) @(negedge clk);

    // 8-bit wrap
    send_b(0, 127, 127);
    send_b(1, -3, -3);
    send_b(0, -128, 1);
    send_b(0, 0, -128);
    idle();
    repeat (4) @(negedge clk);

    // Narrowing 44 -> 24, M = 2
    c_x = '{64'h80000, 64'h7FFFFFFFFFF, 0, 0, 0};
`ifdef COMB_ROUND_EN
    c_e = '{1, 64'h7FFFFF, 0, -8388608, 0};
`else
    c_e = '{0, 64'h7FFFFF, -1, -8388608, 0};
`endif
    for (int i = 0; i < 5; i++) send_c(c_x[i], c_e[i]);
    idle();

    for (int i = 0; i < 100; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0 &&
          err_cyc_a.size() == 0) break;
      @(negedge clk);
    end
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    chk("c_pending", qc.size(), 0);
    chk("a_err_pending", err_cyc_a.size(), 0);
    chk("a_ch_err_count", nerr_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
